feature_pack: RTL
=================

# feature_pack

Stream-to-vector packer that builds the flattened feature bus consumed by the element-wise residual adder. It accepts one signed `data_width` element per handshake and places element k in lane k of a `numofinput*data_width` bus. When a frame is complete, it presents the bus with a valid/ready handshake. It sits between the serial output of a conv/pool stage and the adder's `f_1`/`f_2` inputs, one instance per operand.

## Interface
- `data_width`, 16, element width in bits, two's complement.
- `numofinput`, 100, elements per frame (lanes); must be ≥2.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_data`  in  `data_width`  element value.
- `in_valid`  in  1  element present.
- `in_last`  in  1  element is the last of the frame; only meaningful when `in_valid`.
- `in_ready`  out  1  packer can accept an element.
- `f_out`  out  `numofinput*data_width`  packed frame; lane k is `f_out[k*data_width +: data_width]`.
- `out_valid`  out  1  `f_out` holds a complete frame.
- `out_ready`  in  1  downstream takes the frame.
- `short_frame`  out  1  current frame was closed by `in_last` before all lanes were written.
- `frame_cnt`  out  16  number of frames delivered, wraps at 65535→0.

## Operation
- Two states: FILL (collecting) and FULL (presenting). `in_ready` = (state == FILL). `out_valid` = (state == FULL). Both are derived from registered state only.
- Lane index `idx` counts from 0 to `numofinput-1`, and starts at 0 for every frame.
- FILL, accept (`in_valid`):
  - `f_out` lane `idx` ← `in_data`, stored unmodified with no sign change.
  - If `idx == numofinput-1` or `in_last`: go to FULL and reset `idx` to 0.
  - In the same case, `short_frame` ← `in_last && idx < numofinput-1`.
  - Otherwise `idx` ← `idx+1`.
- FILL with no `in_valid`: everything holds. No timeout.
- `in_last` on lane `numofinput-1` is a normal frame (`short_frame`=0).
- A frame with no `in_last` closes on count alone. The next element begins a new frame.
- FULL: `f_out` is stable. `in_ready`=0, so input is back-pressured.
- FULL, `out_ready`=1:
  - Return to FILL.
  - Clear all lanes of `f_out` to 0, so unwritten lanes of a short frame read 0.
  - Clear `short_frame`.
  - `frame_cnt` ← `frame_cnt+1`.
- No element is accepted in the handshake cycle. Minimum period is `numofinput+1` cycles per full frame.
- Reset, including mid-frame or while FULL, values at the next edge:
  - state FILL, `idx` 0, `f_out` all 0, `short_frame` 0, `frame_cnt` 0.
  - Hence `in_ready`=1 and `out_valid`=0.
  - Partially collected data is discarded.
  - Reset wins over any simultaneous handshake.

## Timing
- All outputs are registered. No combinational path from `in_*` or `out_ready` to any output.
- Latency: `out_valid` rises on the edge that accepts the closing element. The frame is visible in the cycle after that handshake cycle.
- `out_valid`, once high, stays high with `f_out` and `short_frame` stable until the cycle where `out_ready`=1. It falls on that edge.
- `in_ready` falls on the same edge `out_valid` rises, and rises on the edge `out_valid` falls.
- `in_data`/`in_last` are ignored when `in_valid`=0 or `in_ready`=0.
- `out_ready` is ignored in FILL.

## Test plan
Bench uses `numofinput`=4, `data_width`=16.
- Reset then idle:
  - Response: `in_ready`=1, `out_valid`=0, `f_out`=0, `frame_cnt`=0.
- Full frame, back-to-back elements 0x0001, 0xFFFF, 0x7FFF, 0x8000 with `out_ready`=0:
  - Next cycle `out_valid`=1 and `in_ready`=0.
  - `f_out`=0x8000_7FFF_FFFF_0001 (lane 3 in the MSBs), `short_frame`=0.
  - `f_out` holds for 10 cycles, and further `in_valid` is ignored.
- From the previous state, raise `out_ready` for 1 cycle:
  - Next cycle `out_valid`=0, `in_ready`=1, `f_out`=0, `frame_cnt`=1.
- Short frame: 0x0005, then 0x0006 with `in_last`:
  - `out_valid`=1, `short_frame`=1, `f_out`=0x0000_0000_0006_0005.
- Gapped input: elements with `in_valid` toggling every other cycle, `out_ready` held at 1:
  - Correct lane order.
  - Frame presented for exactly 1 cycle.
  - `frame_cnt` increments once per frame.
- Reset asserted after 2 of 4 elements, then a fresh frame 1, 2, 3, 4:
  - Output is 0x0004_0003_0002_0001.
  - No stale lanes, `frame_cnt`=0 before delivery.

Source files
------------

// File: rtl/feature_pack.sv
// feature_pack: serial-to-parallel packer. Collects one signed element per
// accepted beat into lane idx of a wide bus, then presents the whole frame
// on a valid/ready handshake before collecting the next one.
module feature_pack #(
  parameter int data_width = 16,
  parameter int numofinput = 100
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [data_width-1:0]              in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [numofinput*data_width-1:0]   f_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               short_frame,
  output logic [15:0]                        frame_cnt
);

  // Handshake semantics (both ports): a transfer happens on a rising edge
  // where valid and ready are both 1. Ready and valid here come only from
  // registered state, so neither depends combinationally on the partner.

  localparam int IDXW = (numofinput > 1) ? $clog2(numofinput) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(numofinput - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                            state_q, state_d;
  logic [IDXW-1:0]                   idx_q, idx_d;
  logic [numofinput*data_width-1:0]  f_q, f_d;
  logic                              short_q, short_d;
  logic [15:0]                       cnt_q, cnt_d;

  // Next-state logic: write the current lane while filling, clear on delivery.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    f_d     = f_q;
    short_d = short_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          f_d[idx_q*data_width +: data_width] = in_data;
          if ((idx_q == LAST_IDX) || in_last) begin
            state_d = FULL;
            idx_d   = '0;
            // in_last on the final lane is an ordinary full frame
            short_d = in_last && (idx_q != LAST_IDX);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          f_d     = '0;  // unwritten lanes of a later short frame read 0
          short_d = 1'b0;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State registers; reset discards any partial frame and wins over a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      f_q     <= '0;
      short_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      f_q     <= f_d;
      short_q <= short_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == FILL);
  assign out_valid   = (state_q == FULL);
  assign f_out       = f_q;
  assign short_frame = short_q;
  assign frame_cnt   = cnt_q;

endmodule
